// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin line-transfer arbiter between two cache controllers and one memory port
// Winner owns the port for a whole line: one IDLE cycle, BEATS acked beats, one DONE cycle.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int OFFSET_WIDTH  = 6,
  parameter int BEATS         = (2**OFFSET_WIDTH) / (DATA_WIDTH/8)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     beat0,
  output logic                     beat1,
  output logic                     done0,
  output logic                     done1,
  output logic [OFFSET_WIDTH-1:0]  beat_idx,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
    ~((ADDRESS_WIDTH'(1) << OFFSET_WIDTH) - ADDRESS_WIDTH'(1));

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                   state, state_next;
  logic                     owner, owner_next;
  logic                     last_grant, last_grant_next;
  logic                     we_lat, we_next;
  logic [ADDRESS_WIDTH-1:0] base, base_next;
  logic [OFFSET_WIDTH-1:0]  beat_cnt, beat_cnt_next;
  logic                     pick;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  assign pick = req1 & (~req0 | ~last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_lat     <= 1'b0;
      base       <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_grant <= last_grant_next;
      we_lat     <= we_next;
      base       <= base_next;
      beat_cnt   <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_grant_next = last_grant;
    we_next         = we_lat;
    base_next       = base;
    beat_cnt_next   = beat_cnt;
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    beat0           = 1'b0;
    beat1           = 1'b0;
    done0           = 1'b0;
    done1           = 1'b0;
    beat_idx        = '0;
    rdata           = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_next    = pick;
          we_next       = pick ? we1 : we0;
          base_next     = (pick ? addr1 : addr0) & LINE_MASK;
          beat_cnt_next = '0;
          state_next    = BURST;
        end
      end
      BURST: begin
        gnt0      = ~owner;
        gnt1      = owner;
        mem_req   = 1'b1;
        mem_we    = we_lat;
        mem_addr  = base + ADDRESS_WIDTH'(beat_cnt) * ADDRESS_WIDTH'(BYTES);
        mem_wdata = owner ? wdata1 : wdata0;
        beat_idx  = beat_cnt;
        if (mem_ack) begin
          beat0         = ~owner;
          beat1         = owner;
          rdata         = mem_rdata;
          beat_cnt_next = beat_cnt + 1'b1;
          if (beat_cnt == OFFSET_WIDTH'(BEATS - 1)) state_next = DONE;
        end
      end
      DONE: begin
        gnt0            = ~owner;
        gnt1            = owner;
        done0           = ~owner;
        done1           = owner;
        last_grant_next = owner;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Expected values come from transaction-level rules: winner choice, line base, beat count, done cycle.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OW = 6;
  localparam int NB = 16;
  localparam logic [AW-1:0] LMASK = 32'hFFFF_FFC0;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, beat0, beat1, done0, done1;
  logic [OW-1:0] beat_idx;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [7:0]    flags;

  int total = 0;
  int bad   = 0;
  int last_gnt = 1;

  assign flags = {gnt0, gnt1, beat0, beat1, done0, done1, mem_req, mem_we};

  mem_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .beat0(beat0), .beat1(beat1),
    .done0(done0), .done1(done1), .beat_idx(beat_idx), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    assert (!(gnt0 && gnt1)) else $error("FAIL gnt_overlap gnt0=%b gnt1=%b required not both 1", gnt0, gnt1);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; mem_rdata = '0; mem_ack = 0;
    tick;
    reset = 1'b0;
    last_gnt = 1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req0 = 1; req1 = 1; we0 = 1; we1 = 1; mem_ack = 1;
    addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom; mem_rdata = $urandom;
    tick; tick;
    @(negedge clk);
    total++;
    if (flags !== 8'h00) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 8'h00); end
    total++;
    if ({beat_idx, rdata, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_buses idx=%0d rdata=%h addr=%h wdata=%h exp all 0", beat_idx, rdata, mem_addr, mem_wdata);
    end
    do_reset;
  endtask

  task automatic test_refill;
    do_reset;
    req0 = 1; we0 = 0; addr0 = 32'h0000_1234; mem_ack = 1;
    for (int c = 1; c <= 19; c++) begin
      mem_rdata = $urandom; wdata0 = $urandom;
      @(negedge clk);
      total++;
      if (c == 1 || c == 19) begin
        if (flags !== 8'h00) begin bad++; $display("FAIL refill_idle cyc=%0d got=%b exp=%b", c, flags, 8'h00); end
      end else if (c <= 17) begin
        if (flags !== 8'b1010_0010 || mem_addr !== 32'h1200 + 32'(4*(c-2)) || beat_idx !== OW'(c-2) || rdata !== mem_rdata) begin
          bad++; $display("FAIL refill_beat cyc=%0d flags=%b addr=%h idx=%0d rdata=%h exp flags=10100010 addr=%h idx=%0d rdata=%h",
                          c, flags, mem_addr, beat_idx, rdata, 32'h1200 + 32'(4*(c-2)), c-2, mem_rdata);
        end
      end else begin
        if (flags !== 8'b1000_1000) begin bad++; $display("FAIL refill_done cyc=%0d got=%b exp=%b", c, flags, 8'b1000_1000); end
        req0 = 0;
      end
      tick;
    end
    last_gnt = 0;
  endtask

  task automatic test_writeback_stall;
    int acks;
    do_reset;
    req1 = 1; we1 = 1; addr1 = 32'h0000_8040; mem_ack = 0;
    @(negedge clk);
    total++;
    if (flags !== 8'h00) begin bad++; $display("FAIL wb_idle got=%b exp=%b", flags, 8'h00); end
    tick;
    acks = 0;
    for (int cyc = 0; cyc < 64 && acks < NB; cyc++) begin
      mem_ack = cyc[0]; wdata0 = $urandom; wdata1 = $urandom;
      @(negedge clk);
      total++;
      if (flags !== {6'b0100_00 | {3'b000, mem_ack, 2'b00}, 2'b11} || mem_addr !== 32'h8040 + 32'(4*acks)
          || mem_wdata !== wdata1 || beat_idx !== OW'(acks)) begin
        bad++; $display("FAIL wb_beat cyc=%0d flags=%b addr=%h wdata=%h idx=%0d exp addr=%h wdata=%h idx=%0d ack=%b",
                        cyc, flags, mem_addr, mem_wdata, beat_idx, 32'h8040 + 32'(4*acks), wdata1, acks, mem_ack);
      end
      if (mem_ack) acks++;
      tick;
    end
    mem_ack = 0;
    @(negedge clk);
    total++;
    if (flags !== 8'b0100_0100) begin bad++; $display("FAIL wb_done got=%b exp=%b", flags, 8'b0100_0100); end
    req1 = 0;
    tick;
  endtask

  task automatic test_contention;
    int order [4] = '{0, 1, 0, 1};
    logic [AW-1:0] b;
    do_reset;
    req0 = 1; req1 = 1; we0 = 0; we1 = 1; addr0 = $urandom; addr1 = $urandom; mem_ack = 1;
    for (int t = 0; t < 4; t++) begin
      b = (order[t] == 1 ? addr1 : addr0) & LMASK;
      @(negedge clk);
      total++;
      if (flags !== 8'h00) begin bad++; $display("FAIL cont_idle xfer=%0d got=%b exp=%b", t, flags, 8'h00); end
      tick;
      for (int k = 0; k < NB; k++) begin
        @(negedge clk);
        total++;
        if ({gnt0, gnt1, beat0, beat1} !== (order[t] == 1 ? 4'b0101 : 4'b1010) || mem_addr !== b + 32'(4*k)) begin
          bad++; $display("FAIL cont_beat xfer=%0d k=%0d gnt/beat=%b addr=%h exp owner=%0d addr=%h",
                          t, k, {gnt0, gnt1, beat0, beat1}, mem_addr, order[t], b + 32'(4*k));
        end
        tick;
      end
      @(negedge clk);
      total++;
      if ({gnt0, gnt1, done0, done1} !== (order[t] == 1 ? 4'b0101 : 4'b1010)) begin
        bad++; $display("FAIL cont_done xfer=%0d got=%b exp owner=%0d", t, {gnt0, gnt1, done0, done1}, order[t]);
      end
      req0 = (t == 1);
      if (t == 3) req1 = 0;
      tick;
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [AW-1:0] b;
    do_reset;
    req0 = 1; we0 = 0; addr0 = $urandom; mem_ack = 1;
    for (int k = 0; k < 8; k++) tick;
    @(negedge clk);
    total++;
    if (beat_idx !== OW'(7) || beat0 !== 1'b1) begin
      bad++; $display("FAIL rmb_pre idx=%0d beat0=%b exp idx=7 beat0=1", beat_idx, beat0);
    end
    reset = 1; req0 = 0;
    tick;
    reset = 0;
    @(negedge clk);
    total++;
    if (flags !== 8'h00 || {beat_idx, rdata, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL rmb_cleared flags=%b idx=%0d addr=%h rdata=%h wdata=%h exp all 0", flags, beat_idx, mem_addr, rdata, mem_wdata);
    end
    tick;
    req0 = 1; addr0 = $urandom; b = addr0 & LMASK;
    tick;
    @(negedge clk);
    total++;
    if (gnt0 !== 1'b1 || beat_idx !== '0 || mem_addr !== b) begin
      bad++; $display("FAIL rmb_restart gnt0=%b idx=%0d addr=%h exp gnt0=1 idx=0 addr=%h", gnt0, beat_idx, mem_addr, b);
    end
    req0 = 0;
    do_reset;
  endtask

  task automatic test_protocol;
    logic [AW-1:0] b;
    logic wm;
    int cnt;
    do_reset;
    mem_ack = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (flags !== 8'h00 || beat_idx !== '0) begin
        bad++; $display("FAIL proto_spurious cyc=%0d flags=%b idx=%0d exp 0", c, flags, beat_idx);
      end
      tick;
    end
    req0 = 1; we0 = 1'($urandom); addr0 = $urandom; wm = we0; b = addr0 & LMASK;
    tick;
    cnt = 0;
    for (int cyc = 0; cyc < 100 && cnt < NB; cyc++) begin
      mem_ack = 1'($urandom); addr0 = $urandom; we0 = ~we0;
      @(negedge clk);
      total++;
      if (flags !== {1'b1, 1'b0, mem_ack, 3'b000, 1'b1, wm} || mem_addr !== b + 32'(4*cnt)) begin
        bad++; $display("FAIL proto_beat cyc=%0d flags=%b addr=%h exp addr=%h ack=%b we=%b", cyc, flags, mem_addr, b + 32'(4*cnt), mem_ack, wm);
      end
      if (mem_ack) cnt++;
      tick;
    end
    mem_ack = 1;
    @(negedge clk);
    total++;
    if (flags !== 8'b1000_1000) begin bad++; $display("FAIL proto_done got=%b exp=%b", flags, 8'b1000_1000); end
    req0 = 0;
    tick;
  endtask

  task automatic test_random;
    int w, cnt;
    logic wm, ack;
    logic [AW-1:0] b;
    logic [7:0] ef;
    do_reset;
    for (int t = 0; t < 12; t++) begin
      if (!req0 && !req1) begin
        int r = $urandom_range(1, 3);
        req0 = r[0]; req1 = r[1];
      end
      addr0 = $urandom; addr1 = $urandom; we0 = 1'($urandom); we1 = 1'($urandom); mem_ack = 1'($urandom);
      w  = (req0 && req1) ? (last_gnt == 1 ? 0 : 1) : (req1 ? 1 : 0);
      b  = (w == 1 ? addr1 : addr0) & LMASK;
      wm = (w == 1) ? we1 : we0;
      @(negedge clk);
      total++;
      if (flags !== 8'h00) begin bad++; $display("FAIL rand_idle xfer=%0d got=%b exp=%b", t, flags, 8'h00); end
      tick;
      cnt = 0;
      for (int cyc = 0; cyc < 200 && cnt < NB; cyc++) begin
        ack = ($urandom % 4) != 0;
        mem_ack = ack; mem_rdata = $urandom; wdata0 = $urandom; wdata1 = $urandom;
        addr0 = $urandom; addr1 = $urandom; we0 = 1'($urandom); we1 = 1'($urandom);
        if (w == 0 && !req1 && ($urandom % 8) == 0) req1 = 1;
        if (w == 1 && !req0 && ($urandom % 8) == 0) req0 = 1;
        ef = {(w == 0), (w == 1), (ack && w == 0), (ack && w == 1), 2'b00, 1'b1, wm};
        @(negedge clk);
        total++;
        if (flags !== ef || mem_addr !== b + 32'(4*cnt) || beat_idx !== OW'(cnt)
            || mem_wdata !== (w == 1 ? wdata1 : wdata0) || (ack && rdata !== mem_rdata)) begin
          bad++; $display("FAIL rand_beat xfer=%0d cyc=%0d flags=%b addr=%h idx=%0d wdata=%h rdata=%h exp flags=%b addr=%h idx=%0d owner=%0d",
                          t, cyc, flags, mem_addr, beat_idx, mem_wdata, rdata, ef, b + 32'(4*cnt), cnt, w);
        end
        if (ack) cnt++;
        tick;
      end
      mem_ack = 1'($urandom);
      ef = {(w == 0), (w == 1), 2'b00, (w == 0), (w == 1), 2'b00};
      @(negedge clk);
      total++;
      if (flags !== ef) begin bad++; $display("FAIL rand_done xfer=%0d got=%b exp=%b", t, flags, ef); end
      if (w == 1) req1 = 0; else req0 = 0;
      last_gnt = w;
      tick;
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    test_reset;
    test_refill;
    test_writeback_stall;
    test_contention;
    test_reset_mid_burst;
    test_protocol;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
